// File: rtl/bcd_serial_collector_pkg.sv
// Shared definitions for the serial BCD digit collector: bit-position
// encoding, digit limits and the seven-segment lookup table.
package bcd_serial_collector_pkg;

  localparam int unsigned DIG_W      = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned ERRCNT_W   = 8;
  localparam int unsigned BCD_MAX    = 9;
  localparam int unsigned ERRCNT_MAX = 255;

  typedef enum logic [1:0] {
    B0 = 2'd0,
    B1 = 2'd1,
    B2 = 2'd2,
    B3 = 2'd3
  } bit_pos_e;

  // Segment patterns gfedcba, active-high; entries 10..15 show a lone dash.
  localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
    7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000,
    7'b1000000, 7'b1000000, 7'b1101111, 7'b1111111,
    7'b0000111, 7'b1111101, 7'b1101101, 7'b1100110,
    7'b1001111, 7'b1011011, 7'b0000110, 7'b0111111
  };

  function automatic bit_pos_e next_pos(input bit_pos_e pos);
    case (pos)
      B0:      return B1;
      B1:      return B2;
      B2:      return B3;
      default: return B0;
    endcase
  endfunction

endpackage

// File: rtl/bcd_serial_collector_seg7.sv
// Purely combinational nibble to seven-segment decoder.
module bcd_to_seg7
  import bcd_serial_collector_pkg::*;
(
  input  logic [DIG_W-1:0] bcd,
  output logic [SEG_W-1:0] seg_c
);

  assign seg_c = SEG_TABLE[bcd];

endmodule

// File: rtl/bcd_serial_collector.sv
// Collects LSB-first serial bits into BCD nibbles, flags illegal codes,
// keeps a history of legal digits and a saturating error count.
module bcd_serial_collector
  import bcd_serial_collector_pkg::*;
#(
  parameter int unsigned NDIG = 4
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Start,
  input  logic                  Din,
  output logic [DIG_W-1:0]      Digit,
  output logic                  Valid,
  output logic                  Err,
  output logic [SEG_W-1:0]      Seg,
  output logic [4*NDIG-1:0]     Hist,
  output logic [ERRCNT_W-1:0]   ErrCnt
);

  localparam int unsigned HIST_W = DIG_W * NDIG;

  bit_pos_e              state_q,  state_d;
  logic [2:0]            shift_q,  shift_d;
  logic [DIG_W-1:0]      digit_q,  digit_d;
  logic                  valid_q,  valid_d;
  logic                  err_q,    err_d;
  logic [HIST_W-1:0]     hist_q,   hist_d;
  logic [ERRCNT_W-1:0]   errcnt_q, errcnt_d;
  logic [DIG_W-1:0]      nibble;

  // Bit 3 is never stored: it arrives on Din in B3 and goes straight to Digit.
  assign nibble = {Din, shift_q};

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    digit_d  = digit_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    hist_d   = hist_q;
    errcnt_d = errcnt_q;

    if (Start) begin
      state_d = B0;
      shift_d = '0;
    end else begin
      state_d = next_pos(state_q);
      case (state_q)
        B0: shift_d[0] = Din;
        B1: shift_d[1] = Din;
        B2: shift_d[2] = Din;
        default: begin
          digit_d = nibble;
          valid_d = 1'b1;
          if (nibble > DIG_W'(BCD_MAX)) begin
            err_d = 1'b1;
            if (errcnt_q != ERRCNT_W'(ERRCNT_MAX)) begin
              errcnt_d = errcnt_q + ERRCNT_W'(1);
            end
          end else begin
            hist_d = HIST_W'({hist_q, nibble});
          end
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= B0;
      shift_q  <= '0;
      digit_q  <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      hist_q   <= '0;
      errcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      digit_q  <= digit_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      hist_q   <= hist_d;
      errcnt_q <= errcnt_d;
    end
  end

  bcd_to_seg7 u_seg (
    .bcd   (digit_q),
    .seg_c (Seg)
  );

  assign Digit  = digit_q;
  assign Valid  = valid_q;
  assign Err    = err_q;
  assign Hist   = hist_q;
  assign ErrCnt = errcnt_q;

endmodule

// File: tb/tb_bcd_serial_collector.sv
// Directed bench for bcd_serial_collector: vector table plus hand-written
// sequences for reset, re-align and error-count saturation.
module tb_bcd_serial_collector;

  logic        Clk;
  logic        Rst;
  logic        Start;
  logic        Din;
  logic [3:0]  Digit;
  logic        Valid;
  logic        Err;
  logic [6:0]  Seg;
  logic [15:0] Hist;
  logic [7:0]  ErrCnt;

  int tot;
  int bad;

  typedef struct {
    logic        start;
    logic        din;
    logic        valid;
    logic        err;
    logic [3:0]  digit;
    logic [6:0]  seg;
    logic [15:0] hist;
    logic [7:0]  errcnt;
  } vec_t;

  vec_t        vq[$];
  logic [3:0]  p_digit;
  logic [6:0]  p_seg;
  logic [15:0] p_hist;
  logic [7:0]  p_ecnt;

  bcd_serial_collector #(.NDIG(4)) dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .Start  (Start),
    .Din    (Din),
    .Digit  (Digit),
    .Valid  (Valid),
    .Err    (Err),
    .Seg    (Seg),
    .Hist   (Hist),
    .ErrCnt (ErrCnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic s, input logic d);
    Start = s;
    Din   = d;
    @(posedge Clk);
    #1;
    chk("err_without_valid", 32'(Err & ~Valid), 32'd0);
  endtask

  // Four rows for one nibble, LSB first; expected digit state taken from the args.
  task automatic add_dig(input logic [3:0] nib, input logic err, input logic [6:0] seg,
                         input logic [15:0] hist, input logic [7:0] ecnt);
    for (int i = 0; i < 4; i++) begin
      vec_t v;
      v.start  = 1'b0;
      v.din    = nib[i];
      v.valid  = (i == 3);
      v.err    = (i == 3) ? err : 1'b0;
      v.digit  = (i == 3) ? nib : p_digit;
      v.seg    = (i == 3) ? seg : p_seg;
      v.hist   = (i == 3) ? hist : p_hist;
      v.errcnt = (i == 3) ? ecnt : p_ecnt;
      vq.push_back(v);
    end
    p_digit = nib;
    p_seg   = seg;
    p_hist  = hist;
    p_ecnt  = ecnt;
  endtask

  task automatic chk_state(input string tag, input logic v, input logic [3:0] d,
                           input logic [6:0] s, input logic [15:0] h, input logic [7:0] e);
    chk({tag, " valid"},  32'(Valid),  32'(v));
    chk({tag, " digit"},  32'(Digit),  32'(d));
    chk({tag, " seg"},    32'(Seg),    32'(s));
    chk({tag, " hist"},   32'(Hist),   32'(h));
    chk({tag, " errcnt"}, 32'(ErrCnt), 32'(e));
  endtask

  initial begin
    int vcnt;
    tot   = 0;
    bad   = 0;
    Rst   = 1'b0;
    Start = 1'b0;
    Din   = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk_state("reset", 1'b0, 4'h0, 7'b0111111, 16'h0000, 8'd0);
    chk("reset err", 32'(Err), 32'd0);
    Rst = 1'b1;

    p_digit = 4'h0; p_seg = 7'b0111111; p_hist = 16'h0000; p_ecnt = 8'd0;
    add_dig(4'h5, 1'b0, 7'b1101101, 16'h0005, 8'd0);
    add_dig(4'h1, 1'b0, 7'b0000110, 16'h0051, 8'd0);
    add_dig(4'h2, 1'b0, 7'b1011011, 16'h0512, 8'd0);
    add_dig(4'h3, 1'b0, 7'b1001111, 16'h5123, 8'd0);
    add_dig(4'h4, 1'b0, 7'b1100110, 16'h1234, 8'd0);
    add_dig(4'hA, 1'b1, 7'b1000000, 16'h1234, 8'd1);

    foreach (vq[i]) begin
      step(vq[i].start, vq[i].din);
      chk_state($sformatf("row%0d", i), vq[i].valid, vq[i].digit, vq[i].seg,
                vq[i].hist, vq[i].errcnt);
      chk($sformatf("row%0d err", i), 32'(Err), 32'(vq[i].err));
    end

    // Partial digit cut by an asynchronous reset.
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("partial no valid", 32'(Valid), 32'd0);
    Rst = 1'b0;
    #1;
    chk_state("async rst", 1'b0, 4'h0, 7'b0111111, 16'h0000, 8'd0);
    @(posedge Clk);
    #1;
    Rst = 1'b1;
    step(1'b0, 1'b1);
    chk("post rst b0", 32'(Valid), 32'd0);
    step(1'b0, 1'b1);
    chk("post rst b1", 32'(Valid), 32'd0);
    step(1'b0, 1'b0);
    chk("post rst b2", 32'(Valid), 32'd0);
    step(1'b0, 1'b0);
    chk_state("post rst dig", 1'b1, 4'h3, 7'b1001111, 16'h0003, 8'd0);

    // Re-align while in B3 must drop the partial digit without a pulse.
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    chk_state("start in b3", 1'b0, 4'h3, 7'b1001111, 16'h0003, 8'd0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("realign b2", 32'(Valid), 32'd0);
    step(1'b0, 1'b1);
    chk_state("realign dig", 1'b1, 4'h9, 7'b1101111, 16'h0039, 8'd0);
    chk("realign err", 32'(Err), 32'd0);

    // Stream of illegal nibbles drives ErrCnt into saturation.
    vcnt = 0;
    for (int n = 0; n < 260; n++) begin
      for (int b = 0; b < 4; b++) begin
        step(1'b0, 1'b1);
        if (Valid) vcnt++;
      end
      if (n == 253) chk("errcnt 254", 32'(ErrCnt), 32'd254);
      if (n == 254) chk("errcnt 255", 32'(ErrCnt), 32'd255);
    end
    chk("illegal valid count", 32'(vcnt), 32'd260);
    chk_state("saturated", 1'b1, 4'hF, 7'b1000000, 16'h0039, 8'd255);
    chk("saturated err", 32'(Err), 32'd1);
    step(1'b0, 1'b0);
    chk("valid drops", 32'(Valid), 32'd0);
    chk("err drops", 32'(Err), 32'd0);
    chk("digit held", 32'(Digit), 32'hF);

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule

// File: doc/bcd_serial_collector.md
BCD_SERIAL_COLLECTOR -- requirements
Module: bcd_serial_collector

Interface
REQ-001 Parameter: NDIG, 4, number of BCD digits held in the history register (1..8).
REQ-002 Clk  input  1  clock; all state updates on rising edge.
REQ-003 Rst  input  1  reset, asynchronous, active-low.
REQ-004 Start  input  1  synchronous digit re-align, active-high.
REQ-005 Din  input  1  serial BCD bit from the Excess-3-to-BCD converter, one bit per clock, LSB first.
REQ-006 Digit  output  4  last completed nibble, registered.
REQ-007 Valid  output  1  one-cycle pulse: Digit holds a new nibble.
REQ-008 Err  output  1  one-cycle pulse, coincident with Valid, when the new nibble > 9.
REQ-009 Seg  output  7  seven-segment pattern of Digit, bit order gfedcba, active-high.
REQ-010 Hist  output  4*NDIG  last NDIG legal digits; newest in bits [3:0].
REQ-011 ErrCnt  output  8  saturating count of illegal nibbles.

Function
REQ-012 Bit-position FSM states B0, B1, B2, B3; B0->B1->B2->B3->B0, one step per clock when Start=0.
REQ-013 In state Bi, Din is sampled into shift bit i on the rising edge.
REQ-014 On the edge leaving B3, the 4 collected bits load Digit; Valid=1 for exactly the next cycle.
REQ-015 Latency: Valid asserts in the cycle after the 4th bit is sampled; back-to-back digits give Valid every 4th cycle.
REQ-016 Err=1 with Valid when the loaded nibble is 10..15; Err never asserts without Valid.
REQ-017 Legal nibble (0..9): Hist shifts left by 4, new nibble into [3:0], oldest nibble dropped.
REQ-018 Illegal nibble: Hist unchanged; ErrCnt increments, holding at 255.
REQ-019 Start=1: FSM -> B0, partial bits discarded, Din of that cycle ignored; no Valid even if in B3.
REQ-020 Seg decodes Digit combinationally: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, 10..15=1000000.
REQ-021 Digit retains its value between Valid pulses.

Reset
REQ-022 Rst low immediately sets FSM=B0, shift bits=0, Digit=0, Valid=0, Err=0, Hist=0, ErrCnt=0; Seg therefore 0111111.
REQ-023 Rst mid-digit discards partial bits; first edge after release samples bit 0 of a fresh digit.
REQ-024 Rst release is synchronised by the caller; block needs no internal reset synchroniser.

Structure
REQ-025 Shared package holds FSM state encoding (2-bit B0..B3), BCD_MAX=9, ERRCNT_MAX=255, and the segment constant table.
REQ-026 One sub-module, bcd_to_seg7 (4-bit in, 7-bit out, purely combinational), implements REQ-020.
REQ-027 FSM, shift register, Hist and ErrCnt reside in bcd_serial_collector.

Verification
REQ-028 After reset, Din=1,0,1,0 on 4 clocks -> Digit=0101, Valid=1 one cycle, Err=0, Seg=1101101, Hist[3:0]=0101.
REQ-029 Din bits for 1,2,3,4 (NDIG=4), back-to-back -> four Valid pulses 4 cycles apart, Hist=16'h1234.
REQ-030 Din=0,1,0,1 (nibble 1010) -> Valid=1, Err=1, Seg=1000000, Hist unchanged, ErrCnt=1.
REQ-031 Two bits sent, then Rst low one cycle, then bits 1,1,0,0 -> no Valid for partial digit; next Digit=0011.
REQ-032 Start=1 in B3 -> no Valid; next 4 bits 1,0,0,1 -> Digit=1001, Seg=1101111.
REQ-033 260 consecutive illegal nibbles -> ErrCnt=255 and holds; Hist stays 0.
